// File: rtl/keccak_msg_feeder_if.sv
// Byte-stream and keccak-core signals of the message feeder, grouped per side.
// master = feeder side, slave = byte source plus keccak core.
interface keccak_msg_feeder_if;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_last;
   logic        byte_ready;
   logic        core_reset;
   logic [31:0] in;
   logic        in_ready;
   logic        is_last;
   logic [1:0]  byte_num;
   logic        buffer_full;
   logic        out_ready;

   modport master (
      input  byte_in, byte_valid, byte_last, buffer_full, out_ready,
      output byte_ready, core_reset, in, in_ready, is_last, byte_num
   );

   modport slave (
      output byte_in, byte_valid, byte_last, buffer_full, out_ready,
      input  byte_ready, core_reset, in, in_ready, is_last, byte_num
   );
endinterface

// File: rtl/keccak_msg_feeder.sv
// Packs a valid/ready byte stream into keccak 32-bit words (first byte in [31:24]),
// pulses the core reset per message and waits for the digest before the next one.
module keccak_msg_feeder #(
   parameter bit WAIT_DIGEST = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   keccak_msg_feeder_if.master   bus,
   output logic                  busy,
   output logic                  msg_done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_FILL  = 3'd2;
   localparam logic [2:0] S_SEND  = 3'd3;
   localparam logic [2:0] S_PAD   = 3'd4;
   localparam logic [2:0] S_WAIT  = 3'd5;

   logic [2:0]  state;
   logic [1:0]  cnt;
   logic [31:0] word;
   logic        pad_pending;

   logic [31:0] word_nxt;
   logic        accept;
   logic        xfer;
   logic        word_done;
   logic        short_last;

   always_comb begin
      word_nxt = word;
      case (cnt)
         2'd0:    word_nxt[31:24] = bus.byte_in;
         2'd1:    word_nxt[23:16] = bus.byte_in;
         2'd2:    word_nxt[15:8]  = bus.byte_in;
         default: word_nxt[7:0]   = bus.byte_in;
      endcase
      accept     = (state == S_FILL) && bus.byte_valid && bus.byte_ready;
      xfer       = bus.in_ready && !bus.buffer_full;
      word_done  = bus.byte_last || (cnt == 2'd3);
      short_last = bus.byte_last && (cnt != 2'd3);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         cnt            <= '0;
         word           <= '0;
         pad_pending    <= 1'b0;
         bus.byte_ready <= 1'b0;
         bus.core_reset <= 1'b0;
         bus.in         <= '0;
         bus.in_ready   <= 1'b0;
         bus.is_last    <= 1'b0;
         bus.byte_num   <= '0;
         busy           <= 1'b0;
         msg_done       <= 1'b0;
      end else begin
         bus.core_reset <= 1'b0;
         msg_done       <= 1'b0;
         case (state)
            S_IDLE: begin
               // The pending byte is left on the bus; FILL consumes it.
               if (bus.byte_valid) begin
                  state          <= S_CLEAR;
                  bus.core_reset <= 1'b1;
                  busy           <= 1'b1;
               end
            end
            S_CLEAR: begin
               cnt            <= '0;
               word           <= '0;
               pad_pending    <= 1'b0;
               bus.byte_ready <= 1'b1;
               state          <= S_FILL;
            end
            S_FILL: begin
               if (accept) begin
                  if (word_done) begin
                     bus.byte_ready <= 1'b0;
                     bus.in_ready   <= 1'b1;
                     bus.in         <= word_nxt;
                     bus.is_last    <= short_last;
                     bus.byte_num   <= short_last ? cnt + 2'd1 : 2'd0;
                     pad_pending    <= bus.byte_last && (cnt == 2'd3);
                     state          <= S_SEND;
                  end else begin
                     word <= word_nxt;
                     cnt  <= cnt + 2'd1;
                  end
               end
            end
            S_SEND, S_PAD: begin
               if (xfer) begin
                  if (pad_pending) begin
                     // Message ended on a word boundary: an empty last word follows.
                     pad_pending  <= 1'b0;
                     bus.in       <= '0;
                     bus.is_last  <= 1'b1;
                     bus.byte_num <= '0;
                     state        <= S_PAD;
                  end else begin
                     bus.in_ready <= 1'b0;
                     bus.in       <= '0;
                     bus.is_last  <= 1'b0;
                     bus.byte_num <= '0;
                     if (bus.is_last) begin
                        if (WAIT_DIGEST) begin
                           state <= S_WAIT;
                        end else begin
                           state    <= S_IDLE;
                           msg_done <= 1'b1;
                           busy     <= 1'b0;
                        end
                     end else begin
                        cnt            <= '0;
                        word           <= '0;
                        bus.byte_ready <= 1'b1;
                        state          <= S_FILL;
                     end
                  end
               end
            end
            S_WAIT: begin
               if (bus.out_ready) begin
                  msg_done <= 1'b1;
                  busy     <= 1'b0;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// Directed bench for keccak_msg_feeder: a word-list model of each message is checked
// against every presented word, with literal pins on the captured transfers.
module tb_keccak_msg_feeder;

   typedef struct {
      logic [31:0] w;
      logic        l;
      logic [1:0]  n;
   } word_t;

   logic clk = 1'b0;
   logic reset_n;
   logic busy;
   logic msg_done;

   keccak_msg_feeder_if bus();

   keccak_msg_feeder #(.WAIT_DIGEST(1'b1)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .busy     (busy),
      .msg_done (msg_done)
   );

   always #5 clk = ~clk;

   word_t exp_q[$];
   word_t got_q[$];
   int    vectors     = 0;
   int    miscompares = 0;
   int    cr_cnt      = 0;
   logic  cr_prev     = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Expected words of a message: 4 bytes per word, short tail flagged last,
   // or an empty last word when the length is a multiple of 4.
   function automatic void model_msg(input string s);
      word_t      e;
      int         n;
      int         k;
      logic [7:0] b;
      n = s.len();
      for (int i = 0; i < n; i += 4) begin
         k   = (n - i < 4) ? n - i : 4;
         e.w = '0;
         for (int j = 0; j < k; j++) begin
            b   = s[i + j];
            e.w = e.w | ({24'd0, b} << (24 - 8 * j));
         end
         e.l = (k < 4);
         e.n = (k < 4) ? 2'(k) : 2'd0;
         exp_q.push_back(e);
      end
      if (n % 4 == 0) begin
         e.w = '0;
         e.l = 1'b1;
         e.n = 2'd0;
         exp_q.push_back(e);
      end
   endfunction

   always @(negedge clk) begin : compare
      word_t g;
      if (reset_n === 1'b1) begin
         if (bus.core_reset) begin
            cr_cnt++;
            if (cr_prev) chk("core_reset_width", 32'(bus.core_reset), 32'd0);
         end
         cr_prev = bus.core_reset;
         if (bus.in_ready) begin
            chk("ready_overlap", 32'(bus.byte_ready), 32'd0);
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 32'(bus.in_ready), 32'd0);
            end else begin
               chk("word_in", bus.in, exp_q[0].w);
               chk("word_is_last", 32'(bus.is_last), 32'(exp_q[0].l));
               chk("word_byte_num", 32'(bus.byte_num), 32'(exp_q[0].n));
               if (!bus.buffer_full) begin
                  g.w = bus.in;
                  g.l = bus.is_last;
                  g.n = bus.byte_num;
                  got_q.push_back(g);
                  void'(exp_q.pop_front());
               end
            end
         end
         if (msg_done) chk("done_busy_same_cycle", 32'(busy), 32'd0);
      end else begin
         cr_prev = 1'b0;
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic last, output int waited);
      bus.byte_in    = b;
      bus.byte_last  = last;
      bus.byte_valid = 1'b1;
      waited = 0;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         waited++;
         if (bus.byte_ready) break;
      end
      if (!bus.byte_ready) chk("byte_accept_timeout", 32'(bus.byte_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
      chk({tag, "_core_reset"}, 32'(bus.core_reset), 32'd0);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_in"}, bus.in, 32'd0);
      chk({tag, "_is_last"}, 32'(bus.is_last), 32'd0);
      chk({tag, "_byte_num"}, 32'(bus.byte_num), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_msg_done"}, 32'(msg_done), 32'd0);
   endtask

   // hold=1 keeps a next byte pending through WAIT and returns right after msg_done.
   task automatic run_msg(input string s, input bit hold);
      int n;
      int waited;
      int cr0;
      bit cold;
      logic [7:0] b;
      n = s.len();
      @(posedge clk);
      #1;
      got_q.delete();
      model_msg(s);
      cold = !bus.byte_valid && !busy;
      cr0  = cr_cnt;
      for (int i = 0; i < n; i++) begin
         b = s[i];
         send_byte(b, (i == n - 1), waited);
         if (i == 0 && cold) chk("start_latency", 32'(waited), 32'd3);
      end
      bus.byte_last = 1'b0;
      if (hold) bus.byte_in = 8'hEE;
      else      bus.byte_valid = 1'b0;
      @(negedge clk);
      chk("last_word_latency", 32'(bus.in_ready), 32'd1);
      if (n % 4 == 0) begin
         @(negedge clk);
         chk("pad_no_gap_ready", 32'(bus.in_ready), 32'd1);
         chk("pad_no_gap_last", 32'(bus.is_last), 32'd1);
      end
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
      chk("all_words_sent", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
      repeat (3) begin
         @(negedge clk);
         chk("wait_byte_ready", 32'(bus.byte_ready), 32'd0);
         chk("wait_in_ready", 32'(bus.in_ready), 32'd0);
         chk("wait_busy", 32'(busy), 32'd1);
         chk("wait_msg_done", 32'(msg_done), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("done_pulse", 32'(msg_done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_byte_ready", 32'(bus.byte_ready), 32'd0);
      chk("core_reset_count", 32'(cr_cnt), 32'(cr0 + 1));
      if (!hold) begin
         @(negedge clk);
         chk("done_width", 32'(msg_done), 32'd0);
      end
   endtask

   task automatic stall_and_reset_test();
      word_t e;
      int    waited;
      int    cr0;
      @(posedge clk);
      #1;
      got_q.delete();
      cr0 = cr_cnt;
      e.w = 32'h54686520;
      e.l = 1'b0;
      e.n = 2'd0;
      exp_q.push_back(e);
      bus.buffer_full = 1'b1;
      send_byte(8'h54, 1'b0, waited);
      send_byte(8'h68, 1'b0, waited);
      send_byte(8'h65, 1'b0, waited);
      send_byte(8'h20, 1'b0, waited);
      repeat (5) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(bus.in_ready), 32'd1);
         chk("stall_byte_ready", 32'(bus.byte_ready), 32'd0);
         chk("stall_in", bus.in, 32'h54686520);
         chk("stall_no_transfer", 32'(got_q.size()), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.buffer_full = 1'b0;
      send_byte(8'h71, 1'b0, waited);
      send_byte(8'h75, 1'b0, waited);
      chk("stall_one_transfer", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) chk("stall_word", got_q[0].w, 32'h54686520);
      #2;
      reset_n = 1'b0;
      #1;
      check_outputs_zero("rst_mid");
      bus.byte_valid = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      chk("rst_mid_core_resets", 32'(cr_cnt), 32'(cr0 + 1));
   endtask

   initial begin
      reset_n         = 1'b0;
      bus.byte_in     = '0;
      bus.byte_valid  = 1'b0;
      bus.byte_last   = 1'b0;
      bus.buffer_full = 1'b0;
      bus.out_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      reset_n = 1'b1;

      run_msg("Hello, world!", 1'b0);
      chk("hw13_count", 32'(got_q.size()), 32'd4);
      if (got_q.size() == 4) begin
         chk("hw13_w0", got_q[0].w, 32'h48656C6C);
         chk("hw13_w1", got_q[1].w, 32'h6F2C2077);
         chk("hw13_w2", got_q[2].w, 32'h6F726C64);
         chk("hw13_w2_last", 32'(got_q[2].l), 32'd0);
         chk("hw13_w3", got_q[3].w, 32'h21000000);
         chk("hw13_w3_num", 32'(got_q[3].n), 32'd1);
         chk("hw13_w3_last", 32'(got_q[3].l), 32'd1);
      end

      run_msg("Hello, world", 1'b0);
      chk("hw12_count", 32'(got_q.size()), 32'd4);
      if (got_q.size() == 4) begin
         chk("hw12_w2", got_q[2].w, 32'h6F726C64);
         chk("hw12_pad_in", got_q[3].w, 32'd0);
         chk("hw12_pad_num", 32'(got_q[3].n), 32'd0);
         chk("hw12_pad_last", 32'(got_q[3].l), 32'd1);
      end

      run_msg("a", 1'b0);
      chk("single_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() == 1) begin
         chk("single_w", got_q[0].w, 32'h61000000);
         chk("single_num", 32'(got_q[0].n), 32'd1);
      end

      stall_and_reset_test();
      run_msg("abc", 1'b0);
      chk("abc_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() == 1) begin
         chk("abc_w", got_q[0].w, 32'h61626300);
         chk("abc_num", 32'(got_q[0].n), 32'd3);
         chk("abc_last", 32'(got_q[0].l), 32'd1);
      end

      run_msg("xy", 1'b1);
      if (got_q.size() == 1) chk("b2b_first_w", got_q[0].w, 32'h78790000);
      run_msg("Keccak", 1'b0);
      chk("b2b_second_count", 32'(got_q.size()), 32'd2);
      if (got_q.size() == 2) begin
         chk("b2b_second_w0", got_q[0].w, 32'h4B656363);
         chk("b2b_second_w1", got_q[1].w, 32'h616B0000);
         chk("b2b_second_num", 32'(got_q[1].n), 32'd2);
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/keccak_msg_feeder.md
# keccak_msg_feeder

Byte-stream front end for the `keccak` hash core: accepts a message one byte at a time over a valid/ready handshake and packs it into the core's 32-bit word interface (`in`, `in_ready`, `is_last`, `byte_num`), including the trailing-word rules. It issues the per-message core reset, honours `buffer_full` back-pressure and waits for `out_ready` before accepting the next message. It sits between the system byte source and `keccak`; the digest is read directly from `keccak.out`.

## Interface
- `WAIT_DIGEST`, default 1: 1 = after the last word, hold off the next message until `out_ready`; 0 = return to IDLE as soon as the last word is accepted.
- `clk`  in  1  rising-edge clock shared with `keccak`.
- `reset_n`  in  1  asynchronous, active-low reset of this block.
- `byte_in`  in  8  message byte.
- `byte_valid`  in  1  `byte_in` valid.
- `byte_last`  in  1  qualifies `byte_in` as the final byte of the message.
- `byte_ready`  out  1  byte accepted on a rising edge with `byte_valid && byte_ready`.
- `core_reset`  out  1  to `keccak.reset`; active-high, one-cycle pulse at message start.
- `in`  out  32  to `keccak.in`; the first byte of a word is in [31:24].
- `in_ready`  out  1  to `keccak.in_ready`; word presented.
- `is_last`  out  1  to `keccak.is_last`.
- `byte_num`  out  2  to `keccak.byte_num`; number of valid bytes in the last word (0..3).
- `buffer_full`  in  1  from `keccak`; back-pressure.
- `out_ready`  in  1  from `keccak`; digest valid.
- `busy`  out  1  high in every state except IDLE.
- `msg_done`  out  1  one-cycle pulse when the message completes.

## Operation
- All outputs are registered. Reset values are all 0, and the FSM is in IDLE.
- States: IDLE, CLEAR, FILL, SEND, PAD, WAIT.
- IDLE: `byte_ready`=0. When `byte_valid`=1, go to CLEAR. The pending byte is not consumed.
- CLEAR: `core_reset`=1 for exactly one cycle. Clear the byte count and the word register, then go to FILL.
- FILL: `byte_ready`=1. Each accepted byte is written to lane `cnt` (lane 0 = [31:24]) and `cnt` increments.
  - 4th byte with `byte_last`=0: go to SEND with `is_last`=0.
  - `byte_last`=1 at count k = 1..3: go to SEND with `is_last`=1 and `byte_num`=k. Unused low lanes are 0.
  - `byte_last`=1 at count 4: go to SEND with `is_last`=0 and set `pad_pending`.
  - `byte_valid` low: hold indefinitely, with no timeout.
- SEND: `byte_ready`=0 and `in_ready`=1 with the word stable.
  - A word transfers on a rising edge with `in_ready && !buffer_full`. While `buffer_full`=1, hold `in`, `is_last` and `byte_num` unchanged.
  - On transfer with `is_last`=0 and no `pad_pending`: go to FILL with `cnt`=0.
  - On transfer with `pad_pending`: go to PAD.
  - On transfer with `is_last`=1: go to WAIT, or to IDLE with a `msg_done` pulse if `WAIT_DIGEST`=0.
- PAD: present `in`=0, `is_last`=1, `byte_num`=0 with the same transfer rule. After transfer, continue as for a last word.
- WAIT: `in_ready`=0. When `out_ready`=1 is sampled, pulse `msg_done` for one cycle and go to IDLE.
- `in_ready` drops in the cycle after a transfer. A word is never presented twice.
- Reset mid-operation (`reset_n` low): immediate return to IDLE with all outputs 0. The partial word is discarded and `core_reset` is not pulsed. The next message's CLEAR re-initialises `keccak`.

## Timing
- `byte_valid` rising in IDLE: `core_reset` is high on the next edge, and `byte_ready` is high on the edge after that (2-cycle start latency).
- FILL sustains one byte per cycle. Each full word costs 4 FILL cycles plus ≥1 SEND cycle, so an n-byte message with no stall occupies about n + ceil(n/4) cycles of `keccak` input.
- Last word to `in_ready`: 1 cycle after the accepting edge of the final byte. PAD follows SEND with no gap if `buffer_full`=0.
- `msg_done` is asserted the cycle after `out_ready` is sampled high in WAIT.
- `busy` falls in the same cycle that `msg_done` rises.

## Test plan
- "Hello, world!" (13 bytes): expect words 0x48656C6C, 0x6F2C2077, 0x6F726C64 with `is_last`=0, then 0x21000000 with `byte_num`=1 and `is_last`=1. Each is a single-cycle `in_ready` and there is no PAD. The digest matches `keccak` run on the same string.
- "Hello, world" (12 bytes): expect the 3 words above with `is_last`=0, then the PAD word `in`=0, `byte_num`=0, `is_last`=1 on the next cycle.
- Single byte 0x61 with `byte_last`: expect one `core_reset` pulse, then `in`=0x61000000 with `byte_num`=1 and `is_last`=1. `msg_done` pulses once after `out_ready`.
- Force `buffer_full`=1 for 5 cycles during SEND of word 0x54686520: `in_ready` stays 1 and `in` is stable for all 5 cycles, exactly one transfer occurs, and `byte_ready` stays 0 throughout.
- Pulse `reset_n` low after 6 bytes of "The quick": all outputs go to 0 at once and there is no `in_ready`. A following message "abc" starts with `core_reset` and yields 0x61626300 with `byte_num`=3.
- Two back-to-back messages with `WAIT_DIGEST`=1: `byte_ready` stays 0 until `out_ready` for the first message; the second message starts with a fresh `core_reset`.
